// File: rtl/mux_pkg.sv
// Shared types and constants for the round-robin 4:1 mux and its arbiter.
package mux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CNT_W  = 8;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    StEmpty,
    StFull
  } buf_state_e;

  // Channel index arithmetic wraps modulo NUM_CH through the 2-bit type.
  function automatic ch_idx_t ch_add(input ch_idx_t a, input ch_idx_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/rr_mux_4_1_if.sv
// Bundle of the input channels and the registered output port of rr_mux_4_1.
interface rr_mux_4_1_if
  import mux_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0]    in_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  ch_idx_t              out_sel;
  logic                 out_ready;
  logic [CNT_W-1:0]     xfer_cnt;

  // Producer/consumer side: offers words, accepts the output.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, xfer_cnt
  );

  // Mux side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, xfer_cnt
  );

endinterface

// File: rtl/rr_arb_4.sv
// Rotating-priority 4-way arbiter: search starts at ptr, ptr moves past each winner.
module rr_arb_4
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output ch_idx_t           grant_idx,
  output logic              grant_any
);

  ch_idx_t ptr_q, ptr_d;

  // First requesting channel at or above ptr, wrapping modulo 4.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_any && req[ch_add(ptr_q, ch_idx_t'(i))]) begin
        grant_any = 1'b1;
        grant_idx = ch_add(ptr_q, ch_idx_t'(i));
      end
    end
  end

  // One-hot grant vector and pointer advance on an accepted grant only.
  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
    ptr_d = (en && grant_any) ? ch_add(grant_idx, ch_idx_t'(1)) : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rr_mux_4_1.sv
// Round-robin 4:1 mux with a one-entry output register and a transfer counter.
module rr_mux_4_1 #(
  parameter int unsigned DW     = mux_pkg::DW_DEF,
  parameter int unsigned NUM_CH = mux_pkg::NUM_CH
) (
  input logic         clk,
  input logic         rst_n,
  rr_mux_4_1_if.slave bus
);

  import mux_pkg::*;

  buf_state_e        state_q, state_d;
  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] grant;
  ch_idx_t           grant_idx;
  logic              grant_any;
  logic [DW-1:0]     mux_data;
  logic [DW-1:0]     data_q;
  ch_idx_t           sel_q;
  logic [CNT_W-1:0]  cnt_q;

  rr_arb_4 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.in_valid),
    .en        (load_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Load when empty or draining; rst_n gating keeps in_ready low during reset.
  always_comb begin
    state_d = state_q;
    load_en = rst_n && ((state_q == StEmpty) || bus.out_ready);
    if (load_en) begin
      state_d = grant_any ? StFull : StEmpty;
    end
  end

  // Payload of the granted channel.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        mux_data = bus.in_data[k*DW +: DW];
      end
    end
  end

  assign xfer = (state_q == StFull) && bus.out_ready;

  // Output register, state and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load_en && grant_any) begin
        data_q <= mux_data;
        sel_q  <= grant_idx;
      end
    end
  end

  assign bus.in_ready  = load_en ? grant : '0;
  assign bus.out_valid = (state_q == StFull);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_mux_4_1.sv
// Directed, table-driven bench for rr_mux_4_1.
module tb_rr_mux_4_1;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  rr_mux_4_1_if #(.DW(8)) bus ();

  rr_mux_4_1 #(.DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vec [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] D1 = 32'hD3C2B1A0;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = D1;
    bus.out_ready = 1'b1;

    // Reset holds everything idle even with all channels requesting.
    #1;
    check("rst_in_ready_async", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_xfer_cnt", 32'(bus.xfer_cnt), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    rst_n = 1'b1;
    #1;
    check("first_grant_rdy", 32'(bus.in_ready), 32'h1);
    tick();
    check("first_grant_ov", 32'(bus.out_valid), 32'h1);
    check("first_grant_sel", 32'(bus.out_sel), 32'h0);
    check("first_grant_data", 32'(bus.out_data), 32'hA0);

    // Fresh reset before the vector table.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    vec[0]  = '{4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 8'd0};
    vec[1]  = '{4'b0000, D1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 8'd1};
    vec[2]  = '{4'b1000, D1, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 8'd1};
    vec[3]  = '{4'b1111, D1, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 8'd2};
    vec[4]  = '{4'b1111, D1, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 8'd3};
    vec[5]  = '{4'b1111, D1, 1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2, 8'd4};
    vec[6]  = '{4'b1111, D1, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 8'd5};
    vec[7]  = '{4'b1111, D1, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 8'd6};
    vec[8]  = '{4'b1111, D1, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0, 8'd6};
    vec[9]  = '{4'b1111, D1, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0, 8'd6};
    vec[10] = '{4'b1111, D1, 1'b0, 4'b0000, 1'b1, 8'hA0, 2'd0, 8'd6};
    vec[11] = '{4'b1111, D1, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 8'd7};
    vec[12] = '{4'b0001, D1, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 8'd8};
    vec[13] = '{4'b1001, D1, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 8'd9};
    vec[14] = '{4'b1001, D1, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 8'd10};
    vec[15] = '{4'b1001, D1, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 8'd11};
    vec[16] = '{4'b0000, D1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 8'd12};
    vec[17] = '{4'b0000, D1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 8'd12};
    vec[18] = '{4'b0010, D1, 1'b0, 4'b0010, 1'b1, 8'hB1, 2'd1, 8'd12};
    vec[19] = '{4'b0010, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b1, 8'hB1, 2'd1, 8'd12};
    vec[20] = '{4'b0000, D1, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 8'd13};

    for (int i = 0; i < 21; i++) begin
      bus.in_valid  = vec[i].v;
      bus.in_data   = vec[i].d;
      bus.out_ready = vec[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vec[i].rdy));
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vec[i].ov));
      if (vec[i].ov) begin
        check($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vec[i].od));
        check($sformatf("vec%0d_out_sel", i), 32'(bus.out_sel), 32'(vec[i].os));
      end
      check($sformatf("vec%0d_xfer_cnt", i), 32'(bus.xfer_cnt), 32'(vec[i].cnt));
    end

    // Counter wrap: one load edge, then 256 transfers.
    rst_n = 1'b0;
    #1;
    check("wrap_rst_cnt", 32'(bus.xfer_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.in_data   = D1;
    bus.out_ready = 1'b1;
    repeat (256) tick();
    check("wrap_cnt_255", 32'(bus.xfer_cnt), 32'd255);
    tick();
    check("wrap_cnt_0", 32'(bus.xfer_cnt), 32'd0);
    check("wrap_ov", 32'(bus.out_valid), 32'h1);

    // Mid-operation reset drops the held word without waiting for a clock.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ov_async", 32'(bus.out_valid), 32'h0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'h0);
    check("midrst_out_data", 32'(bus.out_data), 32'h0);
    check("midrst_out_sel", 32'(bus.out_sel), 32'h0);
    check("midrst_cnt", 32'(bus.xfer_cnt), 32'h0);
    tick();
    check("midrst_ov_held", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy", 32'(bus.in_ready), 32'h1);
    tick();
    check("post_rst_sel", 32'(bus.out_sel), 32'h0);
    check("post_rst_cnt", 32'(bus.xfer_cnt), 32'h0);
    tick();
    check("post_rst_sel2", 32'(bus.out_sel), 32'h1);
    check("post_rst_cnt2", 32'(bus.xfer_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_4_1.md
RR_MUX_4_1 -- requirements
Module: rr_mux_4_1

Interface
REQ-001 SHALL have parameter DW, default 8, giving the payload width per channel.
REQ-002 SHALL have parameter NUM_CH, fixed at 4, giving the number of input channels.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, width 4: bit k set means channel k offers a word.
REQ-006 SHALL have port in_data, input, width 4*DW: channel k occupies bits [k*DW +: DW].
REQ-007 SHALL have port in_ready, output, width 4: bit k set means the channel k word is accepted this cycle.
REQ-008 SHALL have port out_valid, output, width 1: the output register holds a word.
REQ-009 SHALL have port out_data, output, width DW: the registered payload.
REQ-010 SHALL have port out_sel, output, width 2: the source channel index of out_data.
REQ-011 SHALL have port out_ready, input, width 1: the downstream consumer accepts the word.
REQ-012 SHALL have port xfer_cnt, output, width 8: the count of completed output transfers.

Function
REQ-013 SHALL contain a one-entry output register with states EMPTY and FULL; out_valid=1 exactly in FULL.
REQ-014 SHALL compute load_en = EMPTY or (FULL and out_ready).
REQ-015 SHALL, when load_en and any in_valid are set, grant exactly one channel: the first set in_valid bit searched from ptr upward, modulo 4.
REQ-016 SHALL drive in_ready[k] = load_en and grant[k]; in_ready SHALL be one-hot or zero and SHALL never assert for a channel with in_valid=0.
REQ-017 SHALL, on a grant, load out_data and out_sel on the next edge, enter or stay in FULL, and set ptr = (granted index + 1) mod 4.
REQ-018 SHALL, when load_en is set and no input is valid, go to EMPTY on the edge; ptr SHALL be unchanged.
REQ-019 SHALL hold out_data and out_sel stable while out_valid=1 and out_ready=0.
REQ-020 SHALL have a latency of 1 cycle from input acceptance to out_valid.
REQ-021 SHALL sustain 1 word per cycle when out_ready is held at 1, including a simultaneous drain and load on the same edge.
REQ-022 SHALL increment xfer_cnt on every cycle where out_valid and out_ready are both 1, wrapping from 255 to 0.
REQ-023 SHALL ignore out_ready while EMPTY: no count increment and no state change.
REQ-024 SHALL ignore changes of in_data for channels that are not granted.

Reset
REQ-025 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_sel=0, xfer_cnt=0, ptr=0, state=EMPTY, and in_ready=0, regardless of clk.
REQ-026 SHALL discard any word held in FULL when reset is asserted mid-operation, with no transfer counted.
REQ-027 SHALL permit the first grant on the first rising edge after rst_n deasserts, starting the search at channel 0.

Structure
REQ-028 SHALL take NUM_CH, the default DW, and a 2-bit channel-index typedef from shared package mux_pkg.
REQ-029 SHALL implement the arbitration (ptr register, rotate-priority search, one-hot grant) in sub-module rr_arb_4, instantiated once.
REQ-030 SHALL keep the datapath, the FULL/EMPTY state and xfer_cnt in rr_mux_4_1.

Verification
REQ-031 SHALL check reset: rst_n=0 with in_valid=4'b1111 -> in_ready=0, out_valid=0, xfer_cnt=0; then rst_n=1 -> channel 0 granted first.
REQ-032 SHALL check single source: in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_sel=2.
REQ-033 SHALL check round-robin: in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0, with one word per cycle.
REQ-034 SHALL check backpressure: FULL with out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0, xfer_cnt unchanged; then out_ready=1 -> drain and reload on the same edge.
REQ-035 SHALL check skip: ptr=1 with in_valid=4'b1001 -> channel 3 granted, then channel 0, then channel 3.
REQ-036 SHALL check wrap and mid-reset: 256 transfers -> xfer_cnt=0; rst_n pulsed low while FULL -> out_valid=0 immediately, asynchronously.
